// File: rtl/dct_blk_sequencer.sv
// dct_blk_sequencer
//   Feeds 8x8 pixel blocks (64 pixels) into a 2-D DCT core as one contiguous burst,
//   enforces the core's inter-block gap, and re-times the core output into tagged
//   coefficients (index 0..63, last) with a two-slot latency tracker.
//   Optional build macro: DCT_SEQ_UNDERRUN_CNT_EN adds urun_cnt[7:0], a saturating
//   count of underrun cycles.
//
// Pixel handshake: a pixel transfers on a rising edge where pix_valid & pix_ready.
//   pix_ready is registered and is high exactly during the 64 STREAM cycles of a
//   block. The pixel a source holds while the sequencer leaves IDLE/GAP is taken
//   as pixel 0 in the first STREAM cycle. pix_valid low in STREAM is an underrun:
//   the slot is still consumed and core_xin repeats its previous value.
module dct_blk_sequencer #(
  parameter int PIX_W    = 8,
  parameter int COEF_W   = 12,
  parameter int GAP_CYC  = 83,
  parameter int CORE_LAT = 92
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              en,
  input  logic [PIX_W-1:0]  pix_in,
  input  logic              pix_valid,
  output logic              pix_ready,
  output logic              core_rst,
  output logic [PIX_W-1:0]  core_xin,
  input  logic              core_rdy,
  input  logic [COEF_W-1:0] core_dct,
  output logic [COEF_W-1:0] coef_out,
  output logic              coef_valid,
  output logic [5:0]        coef_idx,
  output logic              coef_last,
  output logic              blk_busy,
  output logic              underrun,
  output logic [15:0]       blk_cnt,
`ifdef DCT_SEQ_UNDERRUN_CNT_EN
  output logic [7:0]        urun_cnt,
`endif
  output logic [1:0]        dbg_state
);

  localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam int LAT_W = $clog2(CORE_LAT + 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);
  localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(CORE_LAT);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_GAP    = 2'd2
  } state_t;

  state_t             state;
  logic [5:0]         pix_cnt;
  logic [GAP_W-1:0]   gap_cnt;
  logic               blk_start;

  logic [1:0]         slot_busy;
  logic [LAT_W-1:0]   slot_cnt [2];
  logic [1:0]         expire;
  logic [1:0]         load;
  logic               run_active;
  logic [5:0]         run_cnt;

  // A block may start from IDLE, or straight out of the final GAP cycle.
  assign blk_start = en & pix_valid &
                     ((state == S_IDLE) | ((state == S_GAP) & (gap_cnt == GAP_LAST)));

  assign dbg_state = state;
  assign blk_busy  = (state != S_IDLE) | (|slot_busy) | run_active | coef_valid;

  // Core reset follows the sequencer reset, inverted and registered.
  always_ff @(posedge CLK) begin
    core_rst <= ~RST;
  end

  // Block FSM: IDLE -> STREAM (64 cycles) -> GAP (GAP_CYC cycles) -> STREAM/IDLE.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state     <= S_IDLE;
      pix_cnt   <= '0;
      gap_cnt   <= '0;
      pix_ready <= 1'b0;
      core_xin  <= '0;
      blk_cnt   <= '0;
      underrun  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (blk_start) begin
            state     <= S_STREAM;
            pix_ready <= 1'b1;
            pix_cnt   <= '0;
            blk_cnt   <= blk_cnt + 16'd1;
          end
        end
        S_STREAM: begin
          if (pix_valid) core_xin <= pix_in;
          else           underrun <= 1'b1;
          if (pix_cnt == 6'd63) begin
            state     <= S_GAP;
            pix_ready <= 1'b0;
            gap_cnt   <= '0;
          end else begin
            pix_cnt <= pix_cnt + 6'd1;
          end
        end
        S_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            if (blk_start) begin
              state     <= S_STREAM;
              pix_ready <= 1'b1;
              pix_cnt   <= '0;
              blk_cnt   <= blk_cnt + 16'd1;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end
        default: begin
          state     <= S_IDLE;
          pix_ready <= 1'b0;
        end
      endcase
    end
  end

`ifdef DCT_SEQ_UNDERRUN_CNT_EN
  // Saturating count of STREAM cycles without a valid pixel.
  always_ff @(posedge CLK) begin
    if (!RST)
      urun_cnt <= '0;
    else if ((state == S_STREAM) && !pix_valid && (urun_cnt != 8'hFF))
      urun_cnt <= urun_cnt + 8'd1;
  end
`endif

  // Slot expiry and allocation; an expiring slot counts as free in the same cycle.
  always_comb begin
    expire = 2'b00;
    load   = 2'b00;
    for (int i = 0; i < 2; i++)
      expire[i] = slot_busy[i] && (slot_cnt[i] == '0);
    if (blk_start) begin
      if (!slot_busy[0] || expire[0])      load[0] = 1'b1;
      else if (!slot_busy[1] || expire[1]) load[1] = 1'b1;
    end
  end

  // Latency slots: count down from CORE_LAT starting at the block-start edge.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      slot_busy <= 2'b00;
      for (int i = 0; i < 2; i++) slot_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (load[i]) begin
          slot_busy[i] <= 1'b1;
          slot_cnt[i]  <= LAT_INIT;
        end else if (expire[i]) begin
          slot_busy[i] <= 1'b0;
        end else if (slot_busy[i]) begin
          slot_cnt[i] <= slot_cnt[i] - LAT_W'(1);
        end
      end
    end
  end

  // Output window: 64 cycles after an expiry, dropped whole if the core is not ready.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      run_active <= 1'b0;
      run_cnt    <= '0;
    end else if ((|expire) && core_rdy) begin
      run_active <= 1'b1;
      run_cnt    <= '0;
    end else if (run_active) begin
      if (run_cnt == 6'd63) run_active <= 1'b0;
      run_cnt <= run_cnt + 6'd1;
    end
  end

  // Registered, tagged coefficient output.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      coef_out   <= '0;
      coef_valid <= 1'b0;
      coef_idx   <= '0;
      coef_last  <= 1'b0;
    end else begin
      coef_valid <= run_active & core_rdy;
      coef_last  <= run_active & core_rdy & (run_cnt == 6'd63);
      coef_idx   <= run_active ? run_cnt : 6'd0;
      if (run_active) coef_out <= core_dct;
    end
  end

endmodule

// File: tb/tb_dct_blk_sequencer.sv
// Bench for dct_blk_sequencer: directed scenarios plus a random phase, checked
// against a block-period model and scoreboard queues for core_xin and coefficients.
module tb_dct_blk_sequencer;
  localparam int PIX_W    = 8;
  localparam int COEF_W   = 12;
  localparam int GAP_CYC  = 83;
  localparam int CORE_LAT = 92;
  localparam int PERIOD   = 64 + GAP_CYC;
  localparam int TAB_N    = 8192;

  // ---------------- clock / reset / DUT ----------------
  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic              RST = 1'b0;
  logic              en = 1'b0;
  logic [PIX_W-1:0]  pix_in = '0;
  logic              pix_valid = 1'b0;
  logic              pix_ready;
  logic              core_rst;
  logic [PIX_W-1:0]  core_xin;
  logic              core_rdy = 1'b1;
  logic [COEF_W-1:0] core_dct = '0;
  logic [COEF_W-1:0] coef_out;
  logic              coef_valid;
  logic [5:0]        coef_idx;
  logic              coef_last;
  logic              blk_busy;
  logic              underrun;
  logic [15:0]       blk_cnt;
  logic [1:0]        dbg_state;
`ifdef DCT_SEQ_UNDERRUN_CNT_EN
  logic [7:0]        urun_cnt;
`endif

  dct_blk_sequencer #(
    .PIX_W(PIX_W), .COEF_W(COEF_W), .GAP_CYC(GAP_CYC), .CORE_LAT(CORE_LAT)
  ) dut (
    .CLK(CLK), .RST(RST), .en(en), .pix_in(pix_in), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .core_rst(core_rst), .core_xin(core_xin),
    .core_rdy(core_rdy), .core_dct(core_dct), .coef_out(coef_out),
    .coef_valid(coef_valid), .coef_idx(coef_idx), .coef_last(coef_last),
    .blk_busy(blk_busy), .underrun(underrun), .blk_cnt(blk_cnt),
`ifdef DCT_SEQ_UNDERRUN_CNT_EN
    .urun_cnt(urun_cnt),
`endif
    .dbg_state(dbg_state)
  );

  // ---------------- bookkeeping ----------------
  int n_cmp = 0;
  int n_bad = 0;
  int e = 0;                       // rising edges seen
  logic [COEF_W-1:0] dct_tab [TAB_N];
  int rdy_lo_from = -1000;
  int rdy_lo_to   = -1000;
  bit kill_next = 1'b0;
  bit mon_on = 1'b0;

  // Reference model: position within the 147-cycle block period (-1 = idle).
  int          mdl_pos = -1;
  logic [15:0] mdl_blk = '0;
  logic        mdl_urun = 1'b0;
  int          mdl_urun_cnt = 0;
  logic [7:0]  mdl_xin = '0;
  logic        mdl_core_rst = 1'b1;

  // Scoreboards. Coefficient entry: {edge[19:0], last, idx[5:0], coef[11:0]}.
  logic [PIX_W-1:0] xin_q[$];
  logic [38:0]      exp_q[$];

  logic prev_ready = 1'b0;
  int   ready_cnt = 0;
  int   coef_seen = 0;
  int   n_last = 0;
  int   dut_starts[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, e);
    end
  endtask

  task automatic fail_empty(input string name, input logic [63:0] act);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got output %0h expected none (edge %0d)", name, act, e);
  endtask

  // A block starting at edge s presents core coefficient k during cycle s+CORE_LAT+1+k,
  // which appears registered on coef_out after edge s+CORE_LAT+2+k.
  task automatic start_block();
    int idx;
    mdl_blk = mdl_blk + 16'd1;
    if (kill_next) begin
      kill_next   = 1'b0;
      rdy_lo_from = e + 80;
      rdy_lo_to   = e + 170;
    end else begin
      for (int k = 0; k < 64; k++) begin
        idx = (e + CORE_LAT + 1 + k) % TAB_N;
        exp_q.push_back({20'(e + CORE_LAT + 2 + k), (k == 63), 6'(k), dct_tab[idx]});
      end
    end
  endtask

  task automatic model_edge(input logic rst_v, input logic en_v, input logic pv_v,
                            input logic [7:0] px);
    mdl_core_rst = !rst_v;
    if (!rst_v) begin
      mdl_pos = -1; mdl_blk = '0; mdl_urun = 1'b0; mdl_urun_cnt = 0; mdl_xin = '0;
      xin_q.delete();
      exp_q.delete();
    end else begin
      if (mdl_pos >= 0 && mdl_pos < 64) begin
        if (pv_v) mdl_xin = px;
        else begin
          mdl_urun = 1'b1;
          if (mdl_urun_cnt < 255) mdl_urun_cnt++;
        end
        xin_q.push_back(mdl_xin);
      end
      if ((mdl_pos == -1 || mdl_pos == PERIOD - 1) && en_v && pv_v) begin
        mdl_pos = 0;
        start_block();
      end else if (mdl_pos == PERIOD - 1) mdl_pos = -1;
      else if (mdl_pos >= 0) mdl_pos++;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input logic rst_v, input logic en_v, input logic pv_v,
                      input logic [7:0] px);
    RST = rst_v; en = en_v; pix_valid = pv_v; pix_in = px;
    core_dct = dct_tab[e % TAB_N];
    core_rdy = !(e >= rdy_lo_from && e <= rdy_lo_to);
    @(posedge CLK);
    e++;
    model_edge(rst_v, en_v, pv_v, px);
    #1;
  endtask

  task automatic idle(input int n, input logic en_v);
    for (int i = 0; i < n; i++) step(1'b1, en_v, 1'b0, 8'h00);
  endtask

  // Waits for a start opportunity, then streams one block. drop_*: stream positions
  // with pix_valid low; en_off_at: stream position from which en is dropped (-1 none).
  task automatic send_block(input int drop_from, input int drop_len, input int en_off_at,
                            input logic [7:0] fixed_px, input bit use_fixed);
    logic v, en_v;
    int guard;
    guard = 0;
    while (!(mdl_pos == -1 || mdl_pos == PERIOD - 1) && guard < 2 * PERIOD) begin
      step(1'b1, 1'b1, 1'b1, 8'($urandom_range(0, 255)));
      guard++;
    end
    step(1'b1, 1'b1, 1'b1, use_fixed ? fixed_px : 8'($urandom_range(0, 255)));
    while (mdl_pos >= 0 && mdl_pos <= 63) begin
      v    = !(mdl_pos >= drop_from && mdl_pos < drop_from + drop_len);
      en_v = !(en_off_at >= 0 && mdl_pos >= en_off_at);
      step(1'b1, en_v, v, use_fixed ? fixed_px : 8'($urandom_range(0, 255)));
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge CLK) begin
    if (mon_on) begin
      check("pix_ready", pix_ready, (mdl_pos >= 0 && mdl_pos < 64));
      check("core_rst", core_rst, mdl_core_rst);
      check("blk_cnt", blk_cnt, mdl_blk);
      check("underrun", underrun, mdl_urun);
`ifdef DCT_SEQ_UNDERRUN_CNT_EN
      check("urun_cnt", urun_cnt, 8'(mdl_urun_cnt));
`endif
      if (pix_ready) ready_cnt++;
      if (pix_ready && !prev_ready) dut_starts.push_back(e);
      if (prev_ready && !core_rst) begin
        if (xin_q.size() == 0) fail_empty("core_xin", core_xin);
        else check("core_xin", core_xin, xin_q.pop_front());
      end
      if (coef_valid) begin
        coef_seen++;
        if (coef_last) n_last++;
        if (exp_q.size() == 0) fail_empty("coef", {e[19:0], coef_last, coef_idx, coef_out});
        else check("coef", {e[19:0], coef_last, coef_idx, coef_out}, exp_q.pop_front());
      end
      prev_ready = pix_ready;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int base, base_last, s;
    for (int i = 0; i < TAB_N; i++) dct_tab[i] = COEF_W'($urandom_range(0, 4095));

    // Reset held for four cycles.
    step(1'b0, 1'b0, 1'b0, 8'h00);
    mon_on = 1'b1;
    repeat (3) step(1'b0, 1'b0, 1'b0, 8'h00);
    check("rst_pix_ready", pix_ready, 1'b0);
    check("rst_coef_valid", coef_valid, 1'b0);
    check("rst_blk_cnt", blk_cnt, 16'd0);
    check("rst_core_rst", core_rst, 1'b1);
    check("rst_blk_busy", blk_busy, 1'b0);
    step(1'b1, 1'b0, 1'b0, 8'h00);
    check("rel_core_rst", core_rst, 1'b0);

    // One block of constant pixels.
    base = ready_cnt;
    send_block(-1, 0, -1, 8'h03, 1'b1);
    check("one_blk_busy", blk_busy, 1'b1);
    check("one_blk_xin", core_xin, 8'h03);
    idle(250, 1'b1);
    check("one_blk_ready_cycles", ready_cnt - base, 64);
    check("one_blk_cnt", blk_cnt, 16'd1);
    check("one_blk_coefs", coef_seen, 64);
    check("one_blk_idle", blk_busy, 1'b0);

    // Three back-to-back blocks.
    base_last = n_last;
    for (int b = 0; b < 3; b++) send_block(-1, 0, -1, 8'h00, 1'b0);
    idle(250, 1'b1);
    s = dut_starts.size();
    check("b2b_spacing_a", dut_starts[s-2] - dut_starts[s-3], PERIOD);
    check("b2b_spacing_b", dut_starts[s-1] - dut_starts[s-2], PERIOD);
    check("b2b_blk_cnt", blk_cnt, 16'd4);
    check("b2b_last_pulses", n_last - base_last, 3);

    // Underrun at pixels 20..22.
    check("pre_underrun", underrun, 1'b0);
    send_block(20, 3, -1, 8'h00, 1'b0);
    check("underrun_set", underrun, 1'b1);
`ifdef DCT_SEQ_UNDERRUN_CNT_EN
    check("urun_cnt_3", urun_cnt, 8'd3);
`endif
    idle(250, 1'b1);

    // en dropped at pixel 10: block completes, then no new block while en=0.
    send_block(-1, 0, 10, 8'h00, 1'b0);
    base = ready_cnt;
    for (int i = 0; i < 250; i++) step(1'b1, 1'b0, 1'b1, 8'($urandom_range(0, 255)));
    check("en_off_no_ready", ready_cnt - base, 0);
    check("en_off_idle", blk_busy, 1'b0);

    // Reset at pixel 30 aborts the block.
    step(1'b1, 1'b1, 1'b1, 8'($urandom_range(0, 255)));
    while (mdl_pos >= 0 && mdl_pos < 30) step(1'b1, 1'b1, 1'b1, 8'($urandom_range(0, 255)));
    step(1'b0, 1'b1, 1'b1, 8'h00);
    check("abort_pix_ready", pix_ready, 1'b0);
    check("abort_blk_cnt", blk_cnt, 16'd0);
    check("abort_underrun", underrun, 1'b0);
    check("abort_core_rst", core_rst, 1'b1);
    check("abort_xin", core_xin, 8'h00);
    base = coef_seen;
    idle(250, 1'b0);
    check("abort_no_coefs", coef_seen - base, 0);

    // Core not ready across a block's expiry: that block yields nothing.
    kill_next = 1'b1;
    base = coef_seen;
    send_block(-1, 0, -1, 8'h00, 1'b0);
    idle(300, 1'b1);
    check("rdy_low_suppressed", coef_seen - base, 0);

    // Random phase.
    for (int i = 0; i < 1500; i++)
      step(1'b1, ($urandom_range(0, 9) != 0), ($urandom_range(0, 9) != 0),
           8'($urandom_range(0, 255)));
    idle(400, 1'b0);

    check("final_coef_q_empty", exp_q.size(), 0);
    check("final_xin_q_empty", xin_q.size(), 0);
    check("final_blk_busy", blk_busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global time limit.
  initial begin
    #400000;
    n_cmp++;
    n_bad++;
    $display("FAIL timeout: run did not complete (edge %0d)", e);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
